atm_key_entry: RTL and testbench
================================

ATM_KEY_ENTRY -- requirements
Module: atm_key_entry

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3: failed PIN attempts before lockout.
REQ-002 SHALL have parameter TIMEOUT, default 1000: idle clk cycles allowed during digit entry.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 card_inserted  input  1  card present level.
REQ-006 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-007 key_code  input  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC CANCEL, 4'hD-4'hF illegal.
REQ-008 auth_valid  input  1  one-cycle strobe from the ATM core with its authentication verdict.
REQ-009 auth_ok  input  1  verdict, qualified by auth_valid.
REQ-010 accNumber  output  12  assembled account number, feeds the ATM core.
REQ-011 pin  output  4  entered PIN digit, feeds the ATM core.
REQ-012 auth_req  output  1  one-cycle pulse: accNumber/pin valid, request authentication.
REQ-013 session_active  output  1  high while authenticated.
REQ-014 locked  output  1  high after MAX_TRIES failures.
REQ-015 entry_error  output  1  one-cycle pulse on any rejected key, overflow or timeout.
REQ-016 state  output  3  current FSM state code.

Function
REQ-017 States SHALL be IDLE=0, ACC_ENTRY=1, PIN_ENTRY=2, AUTH_WAIT=3, SESSION=4, LOCKED=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-018 IDLE: card_inserted=1 -> ACC_ENTRY, with accNumber, pin, digit count and idle timer cleared.
REQ-019 ACC_ENTRY digit d with count<4: acc = acc*10+d computed at 14 bits, count+1; digit with count=4: ignored, entry_error.
REQ-020 ACC_ENTRY ENTER: count=4 and value<=4095 -> PIN_ENTRY, count cleared; otherwise entry_error, acc and count cleared, stay.
REQ-021 CLEAR in ACC_ENTRY or PIN_ENTRY: clears the field being entered and count, no error.
REQ-022 PIN_ENTRY digit: pin=d, count=1 (later digits overwrite); ENTER with count=1 -> AUTH_WAIT and auth_req=1 for exactly that transition cycle; ENTER with count=0 -> entry_error, stay.
REQ-023 AUTH_WAIT: keys ignored without error; auth_valid&auth_ok -> SESSION, try counter cleared.
REQ-024 AUTH_WAIT auth_valid&!auth_ok: tries+1; if new tries==MAX_TRIES -> LOCKED, else -> PIN_ENTRY with pin and count cleared.
REQ-025 SESSION: session_active=1, accNumber/pin held stable; CANCEL -> IDLE.
REQ-026 CANCEL in ACC_ENTRY/PIN_ENTRY -> IDLE, fields cleared, no error.
REQ-027 card_inserted=0 in any state except IDLE and LOCKED -> IDLE, fields and tries cleared; takes priority over a simultaneous key or auth_valid.
REQ-028 LOCKED: locked=1, all keys and auth_valid ignored, exits only via rst.
REQ-029 Idle timer counts clk cycles in ACC_ENTRY/PIN_ENTRY, cleared by every key_valid; reaching TIMEOUT -> IDLE, fields cleared, entry_error pulse.
REQ-030 Illegal key codes 4'hD-4'hF in ACC_ENTRY/PIN_ENTRY: entry_error, no other effect; in other states ignored silently.
REQ-031 key_valid while auth_valid in AUTH_WAIT: auth_valid processed, key dropped.
REQ-032 Outputs SHALL be registered; accNumber/pin are cleared in IDLE.

Reset
REQ-033 rst=1 at a rising edge SHALL force state=IDLE, accNumber=0, pin=0, tries=0, timer=0, count=0, auth_req=0, session_active=0, locked=0, entry_error=0, from any state including AUTH_WAIT and LOCKED.

Verification
REQ-034 Card in, keys 2,1,7,8,ENTER,4,ENTER -> auth_req one cycle, accNumber=2178, pin=4; auth_valid&auth_ok -> session_active=1, state=4.
REQ-035 Keys 5,0,0,0,ENTER -> entry_error pulse, accNumber=0, state stays ACC_ENTRY; 6th digit after 4 -> entry_error.
REQ-036 Three auth_valid with auth_ok=0 (re-entering PIN each time) -> PIN_ENTRY after 1st/2nd, locked=1, state=5 after 3rd; card removal leaves LOCKED.
REQ-037 TIMEOUT=8, card in, key 2, then 8 idle cycles -> entry_error, state=IDLE, accNumber=0.
REQ-038 rst asserted in AUTH_WAIT -> next cycle all outputs 0, state=IDLE; card removed in SESSION with simultaneous CANCEL -> IDLE, single transition.

Source files
------------

// File: rtl/atm_key_entry.sv
// -----------------------------------------------------------------------------
// atm_key_entry
//
// Keypad front end for an ATM. Collects a 4-digit account number and a
// single-digit PIN, requests authentication from the ATM core, and tracks the
// resulting session. Too many rejected PINs lock the terminal until reset.
// Long keypad inactivity during digit entry abandons the transaction.
//
// Parameters
//   MAX_TRIES      rejected PIN attempts that lock the terminal
//   TIMEOUT        idle clk cycles tolerated during account/PIN entry
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   card_inserted  card present level
//   key_valid      one-cycle strobe qualifying key_code
//   key_code       0-9 digit, A ENTER, B CLEAR, C CANCEL, D-F illegal
//   auth_valid     one-cycle strobe carrying the core's verdict
//   auth_ok        verdict, qualified by auth_valid
//   accNumber      assembled account number (registered)
//   pin            entered PIN digit (registered)
//   auth_req       one-cycle pulse: accNumber/pin are ready for the core
//   session_active high while authenticated
//   locked         high after MAX_TRIES rejected PINs
//   entry_error    one-cycle pulse on a rejected key, overflow or timeout
//   state          current FSM state code
// -----------------------------------------------------------------------------
module atm_key_entry #(
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_inserted,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_valid,
    input  logic        auth_ok,
    output logic [11:0] accNumber,
    output logic [3:0]  pin,
    output logic        auth_req,
    output logic        session_active,
    output logic        locked,
    output logic        entry_error,
    output logic [2:0]  state
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    // Timer value seen on the cycle whose idle edge completes TIMEOUT cycles.
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACC_ENTRY = 3'd1,
        S_PIN_ENTRY = 3'd2,
        S_AUTH_WAIT = 3'd3,
        S_SESSION   = 3'd4,
        S_LOCKED    = 3'd5
    } state_t;

    state_t           state_q,          state_d;
    logic [13:0]      acc_q,            acc_d;
    logic [3:0]       pin_q,            pin_d;
    logic [2:0]       cnt_q,            cnt_d;
    logic [TMR_W-1:0] timer_q,          timer_d;
    logic [TRY_W-1:0] tries_q,          tries_d;
    logic             auth_req_q,       auth_req_d;
    logic             entry_error_q,    entry_error_d;
    logic             session_active_q, session_active_d;
    logic             locked_q,         locked_d;

    logic             is_digit;
    logic             is_illegal;
    logic [13:0]      acc_shift;
    logic [TRY_W-1:0] tries_inc;

    assign is_digit   = (key_code <= 4'd9);
    assign is_illegal = (key_code > KEY_CANCEL);
    // 4 digits reach at most 9999, so 14 bits hold the value before the
    // range check against the 12-bit account field.
    assign acc_shift  = acc_q * 14'd10 + {10'd0, key_code};
    assign tries_inc  = tries_q + TRY_W'(1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal gets a default before any branch so no path
        // leaves it unassigned and infers a latch.
        state_d       = state_q;
        acc_d         = acc_q;
        pin_d         = pin_q;
        cnt_d         = cnt_q;
        timer_d       = '0;
        tries_d       = tries_q;
        auth_req_d    = 1'b0;
        entry_error_d = 1'b0;

        // Card removal abandons any active transaction and wins over a key or
        // verdict arriving in the same cycle. LOCKED deliberately ignores it.
        if (!card_inserted &&
            (state_q inside {S_ACC_ENTRY, S_PIN_ENTRY, S_AUTH_WAIT, S_SESSION})) begin
            state_d = S_IDLE;
            acc_d   = '0;
            pin_d   = '0;
            cnt_d   = '0;
            tries_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    acc_d = '0;
                    pin_d = '0;
                    cnt_d = '0;
                    if (card_inserted) begin
                        state_d = S_ACC_ENTRY;
                    end
                end

                S_ACC_ENTRY: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            if (cnt_q < 3'd4) begin
                                acc_d = acc_shift;
                                cnt_d = cnt_q + 3'd1;
                            end else begin
                                entry_error_d = 1'b1;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            if (cnt_q == 3'd4 && acc_q <= 14'd4095) begin
                                state_d = S_PIN_ENTRY;
                                cnt_d   = '0;
                            end else begin
                                entry_error_d = 1'b1;
                                acc_d         = '0;
                                cnt_d         = '0;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            acc_d = '0;
                            cnt_d = '0;
                        end else if (key_code == KEY_CANCEL) begin
                            state_d = S_IDLE;
                            acc_d   = '0;
                            pin_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            entry_error_d = 1'b1;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_d       = S_IDLE;
                        acc_d         = '0;
                        pin_d         = '0;
                        cnt_d         = '0;
                        entry_error_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end

                S_PIN_ENTRY: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            // Single-digit PIN: later digits overwrite.
                            pin_d = key_code;
                            cnt_d = 3'd1;
                        end else if (key_code == KEY_ENTER) begin
                            if (cnt_q == 3'd1) begin
                                state_d    = S_AUTH_WAIT;
                                auth_req_d = 1'b1;
                            end else begin
                                entry_error_d = 1'b1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            pin_d = '0;
                            cnt_d = '0;
                        end else if (key_code == KEY_CANCEL) begin
                            state_d = S_IDLE;
                            acc_d   = '0;
                            pin_d   = '0;
                            cnt_d   = '0;
                        end else if (is_illegal) begin
                            entry_error_d = 1'b1;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        state_d       = S_IDLE;
                        acc_d         = '0;
                        pin_d         = '0;
                        cnt_d         = '0;
                        entry_error_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end

                S_AUTH_WAIT: begin
                    // Keys are dropped here, including one coinciding with
                    // the verdict.
                    if (auth_valid) begin
                        if (auth_ok) begin
                            state_d = S_SESSION;
                            tries_d = '0;
                        end else begin
                            tries_d = tries_inc;
                            pin_d   = '0;
                            cnt_d   = '0;
                            if (tries_inc == TRY_LIMIT) begin
                                state_d = S_LOCKED;
                            end else begin
                                state_d = S_PIN_ENTRY;
                            end
                        end
                    end
                end

                S_SESSION: begin
                    if (key_valid && key_code == KEY_CANCEL) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        pin_d   = '0;
                        cnt_d   = '0;
                    end
                end

                S_LOCKED: begin
                    // Only reset leaves this state.
                end

                default: begin
                    // Unused encodings recover to IDLE.
                    state_d = S_IDLE;
                    acc_d   = '0;
                    pin_d   = '0;
                    cnt_d   = '0;
                    tries_d = '0;
                end
            endcase
        end

        // Status outputs follow the next state so they are registered
        // alongside it rather than decoded from state_q.
        session_active_d = (state_d == S_SESSION);
        locked_d         = (state_d == S_LOCKED);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order.
        if (rst) begin
            state_q          <= S_IDLE;
            acc_q            <= '0;
            pin_q            <= '0;
            cnt_q            <= '0;
            timer_q          <= '0;
            tries_q          <= '0;
            auth_req_q       <= 1'b0;
            entry_error_q    <= 1'b0;
            session_active_q <= 1'b0;
            locked_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            pin_q            <= pin_d;
            cnt_q            <= cnt_d;
            timer_q          <= timer_d;
            tries_q          <= tries_d;
            auth_req_q       <= auth_req_d;
            entry_error_q    <= entry_error_d;
            session_active_q <= session_active_d;
            locked_q         <= locked_d;
        end
    end

    assign accNumber      = acc_q[11:0];
    assign pin            = pin_q;
    assign auth_req       = auth_req_q;
    assign session_active = session_active_q;
    assign locked         = locked_q;
    assign entry_error    = entry_error_q;
    assign state          = state_q;

endmodule

// File: tb/tb_atm_key_entry.sv
// -----------------------------------------------------------------------------
// tb_atm_key_entry
//
// Directed bench for atm_key_entry. Each step drives inputs for one clock,
// pushes the expected registered outputs to a scoreboard, and pops/compares
// them one time unit after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_atm_key_entry;

    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACC  = 3'd1;
    localparam logic [2:0] ST_PIN  = 3'd2;
    localparam logic [2:0] ST_AUTH = 3'd3;
    localparam logic [2:0] ST_SESS = 3'd4;
    localparam logic [2:0] ST_LOCK = 3'd5;

    // Flag nibble = {auth_req, session_active, locked, entry_error}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_REQ  = 4'b1000;
    localparam logic [3:0] F_SES  = 4'b0100;
    localparam logic [3:0] F_LCK  = 4'b0010;
    localparam logic [3:0] F_ERR  = 4'b0001;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [3:0] K_CANCEL = 4'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_inserted;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        auth_valid;
    logic        auth_ok;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic        auth_req;
    logic        session_active;
    logic        locked;
    logic        entry_error;
    logic [2:0]  state;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [11:0] acc;
        logic [3:0]  pin;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    atm_key_entry #(
        .MAX_TRIES (MAX_TRIES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .card_inserted  (card_inserted),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .auth_valid     (auth_valid),
        .auth_ok        (auth_ok),
        .accNumber      (accNumber),
        .pin            (pin),
        .auth_req       (auth_req),
        .session_active (session_active),
        .locked         (locked),
        .entry_error    (entry_error),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
    endtask

    task automatic verdict(input logic ok);
        auth_valid = 1'b1;
        auth_ok    = ok;
    endtask

    // One clock with the currently driven inputs; strobes drop afterwards.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] acc,
                       input logic [3:0] p, input logic [3:0] fl);
        exp_t e;
        exp_t got;
        e.tag   = tag;
        e.st    = st;
        e.acc   = acc;
        e.pin   = p;
        e.flags = fl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        auth_valid = 1'b0;
        auth_ok    = 1'b0;
        got = sb.pop_front();
        check({got.tag, ".state"}, 16'(state),     16'(got.st));
        check({got.tag, ".acc"},   16'(accNumber), 16'(got.acc));
        check({got.tag, ".pin"},   16'(pin),       16'(got.pin));
        check({got.tag, ".flags"},
              16'({auth_req, session_active, locked, entry_error}), 16'(got.flags));
    endtask

    initial begin
        rst           = 1'b1;
        card_inserted = 1'b0;
        key_valid     = 1'b0;
        key_code      = 4'h0;
        auth_valid    = 1'b0;
        auth_ok       = 1'b0;

        cyc("reset", ST_IDLE, 12'd0, 4'd0, F_NONE);
        rst = 1'b0;
        cyc("idle_no_card", ST_IDLE, 12'd0, 4'd0, F_NONE);

        // Successful transaction 2178 / 4
        card_inserted = 1'b1;
        cyc("t1_card", ST_ACC, 12'd0, 4'd0, F_NONE);
        press(4'd2);    cyc("t1_d2", ST_ACC, 12'd2, 4'd0, F_NONE);
        press(4'd1);    cyc("t1_d1", ST_ACC, 12'd21, 4'd0, F_NONE);
        press(4'd7);    cyc("t1_d7", ST_ACC, 12'd217, 4'd0, F_NONE);
        press(4'd8);    cyc("t1_d8", ST_ACC, 12'd2178, 4'd0, F_NONE);
        press(K_ENTER); cyc("t1_acc_ent", ST_PIN, 12'd2178, 4'd0, F_NONE);
        press(4'd4);    cyc("t1_pin4", ST_PIN, 12'd2178, 4'd4, F_NONE);
        press(K_ENTER); cyc("t1_pin_ent", ST_AUTH, 12'd2178, 4'd4, F_REQ);
        cyc("t1_req_drop", ST_AUTH, 12'd2178, 4'd4, F_NONE);
        verdict(1'b1);  cyc("t1_auth_ok", ST_SESS, 12'd2178, 4'd4, F_SES);
        press(4'd5);    cyc("t1_sess_key", ST_SESS, 12'd2178, 4'd4, F_SES);
        // Card removal together with CANCEL: one transition to IDLE
        card_inserted = 1'b0;
        press(K_CANCEL); cyc("t1_remove", ST_IDLE, 12'd0, 4'd0, F_NONE);
        cyc("t1_idle", ST_IDLE, 12'd0, 4'd0, F_NONE);

        // Account overflow, extra digits, illegal key, CLEAR, 4095 boundary
        card_inserted = 1'b1;
        cyc("t2_card", ST_ACC, 12'd0, 4'd0, F_NONE);
        press(4'd5);    cyc("t2_d5", ST_ACC, 12'd5, 4'd0, F_NONE);
        press(4'd0);    cyc("t2_d0a", ST_ACC, 12'd50, 4'd0, F_NONE);
        press(4'd0);    cyc("t2_d0b", ST_ACC, 12'd500, 4'd0, F_NONE);
        press(4'd0);    cyc("t2_d0c", ST_ACC, 12'd904, 4'd0, F_NONE);  // 5000 mod 4096
        press(4'd0);    cyc("t2_5th", ST_ACC, 12'd904, 4'd0, F_ERR);
        press(4'd9);    cyc("t2_6th", ST_ACC, 12'd904, 4'd0, F_ERR);
        press(K_ENTER); cyc("t2_ovf_ent", ST_ACC, 12'd0, 4'd0, F_ERR);
        cyc("t2_err_drop", ST_ACC, 12'd0, 4'd0, F_NONE);
        press(4'hD);    cyc("t2_illegal", ST_ACC, 12'd0, 4'd0, F_ERR);
        press(4'd3);    cyc("t2_d3", ST_ACC, 12'd3, 4'd0, F_NONE);
        press(K_CLEAR); cyc("t2_clear", ST_ACC, 12'd0, 4'd0, F_NONE);
        press(K_ENTER); cyc("t2_short_ent", ST_ACC, 12'd0, 4'd0, F_ERR);
        press(4'd4);    cyc("t2_b4", ST_ACC, 12'd4, 4'd0, F_NONE);
        press(4'd0);    cyc("t2_b0", ST_ACC, 12'd40, 4'd0, F_NONE);
        press(4'd9);    cyc("t2_b9", ST_ACC, 12'd409, 4'd0, F_NONE);
        press(4'd5);    cyc("t2_b5", ST_ACC, 12'd4095, 4'd0, F_NONE);
        press(K_ENTER); cyc("t2_max_ent", ST_PIN, 12'd4095, 4'd0, F_NONE);
        press(K_ENTER); cyc("t2_pin_empty", ST_PIN, 12'd4095, 4'd0, F_ERR);
        press(4'hF);    cyc("t2_pin_illegal", ST_PIN, 12'd4095, 4'd0, F_ERR);
        press(4'd6);    cyc("t2_pin6", ST_PIN, 12'd4095, 4'd6, F_NONE);
        press(K_CLEAR); cyc("t2_pin_clear", ST_PIN, 12'd4095, 4'd0, F_NONE);

        // Three rejected PINs lock the terminal
        press(4'd7);    cyc("t3_pin7", ST_PIN, 12'd4095, 4'd7, F_NONE);
        press(K_ENTER); cyc("t3_req1", ST_AUTH, 12'd4095, 4'd7, F_REQ);
        press(4'd3); verdict(1'b0);
        cyc("t3_fail1", ST_PIN, 12'd4095, 4'd0, F_NONE);
        press(4'd1);    cyc("t3_pin1", ST_PIN, 12'd4095, 4'd1, F_NONE);
        press(K_ENTER); cyc("t3_req2", ST_AUTH, 12'd4095, 4'd1, F_REQ);
        verdict(1'b0);  cyc("t3_fail2", ST_PIN, 12'd4095, 4'd0, F_NONE);
        press(4'd2);    cyc("t3_pin2", ST_PIN, 12'd4095, 4'd2, F_NONE);
        press(K_ENTER); cyc("t3_req3", ST_AUTH, 12'd4095, 4'd2, F_REQ);
        verdict(1'b0);  cyc("t3_fail3", ST_LOCK, 12'd4095, 4'd0, F_LCK);
        card_inserted = 1'b0;
        cyc("t3_lock_nocard", ST_LOCK, 12'd4095, 4'd0, F_LCK);
        press(K_CANCEL); verdict(1'b1);
        cyc("t3_lock_ignore", ST_LOCK, 12'd4095, 4'd0, F_LCK);
        card_inserted = 1'b1;
        cyc("t3_lock_card", ST_LOCK, 12'd4095, 4'd0, F_LCK);

        // Reset out of LOCKED, then reset out of AUTH_WAIT
        rst = 1'b1;
        cyc("t4_rst_lock", ST_IDLE, 12'd0, 4'd0, F_NONE);
        rst = 1'b0;
        cyc("t4_card", ST_ACC, 12'd0, 4'd0, F_NONE);
        press(4'd1);    cyc("t4_d1", ST_ACC, 12'd1, 4'd0, F_NONE);
        press(4'd2);    cyc("t4_d2", ST_ACC, 12'd12, 4'd0, F_NONE);
        press(4'd3);    cyc("t4_d3", ST_ACC, 12'd123, 4'd0, F_NONE);
        press(4'd4);    cyc("t4_d4", ST_ACC, 12'd1234, 4'd0, F_NONE);
        press(K_ENTER); cyc("t4_acc_ent", ST_PIN, 12'd1234, 4'd0, F_NONE);
        press(4'd9);    cyc("t4_pin9", ST_PIN, 12'd1234, 4'd9, F_NONE);
        press(K_ENTER); cyc("t4_req", ST_AUTH, 12'd1234, 4'd9, F_REQ);
        press(4'd5);    cyc("t4_auth_key", ST_AUTH, 12'd1234, 4'd9, F_NONE);
        rst = 1'b1;
        cyc("t4_rst_auth", ST_IDLE, 12'd0, 4'd0, F_NONE);
        rst = 1'b0;
        cyc("t5_card", ST_ACC, 12'd0, 4'd0, F_NONE);

        // Inactivity timeout: TIMEOUT idle cycles after the last key
        press(4'd2);    cyc("t5_d2", ST_ACC, 12'd2, 4'd0, F_NONE);
        for (int i = 1; i < TIMEOUT; i++) begin
            cyc($sformatf("t5_wait%0d", i), ST_ACC, 12'd2, 4'd0, F_NONE);
        end
        cyc("t5_timeout", ST_IDLE, 12'd0, 4'd0, F_ERR);
        cyc("t5_recard", ST_ACC, 12'd0, 4'd0, F_NONE);
        press(4'd3);     cyc("t5_d3", ST_ACC, 12'd3, 4'd0, F_NONE);
        press(K_CANCEL); cyc("t5_cancel", ST_IDLE, 12'd0, 4'd0, F_NONE);
        card_inserted = 1'b0;
        cyc("t5_end", ST_IDLE, 12'd0, 4'd0, F_NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
